// File: rtl/data_mem_ext_if.sv
// Bus between the MEM stage and the data memory: request, store data,
// access size/extension control, and the load/busy/fault responses.
interface data_mem_ext_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Fault;

    modport master (
        output Address, WriteData, MemRead, MemWrite, Size, Unsigned,
        input  ReadData, Busy, Fault
    );

    modport slave (
        input  Address, WriteData, MemRead, MemWrite, Size, Unsigned,
        output ReadData, Busy, Fault
    );
endinterface

// File: rtl/data_mem_ext.sv
// MIPS data memory: word array with byte/half/word access, sign or zero
// extended loads, alignment and range faults, and a post-reset clear sweep
// that zeroes one word per cycle. Read port is combinational or registered.
module data_mem_ext #(
    parameter int DEPTH    = 32,
    parameter bit REG_READ = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_ext_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    state_t        state;
    logic [AW-1:0] counter;
    logic [31:0]   mem [DEPTH];

    logic          busy;
    logic          req;
    logic          misalign;
    logic          out_of_range;
    logic          fault;
    logic          store_en;
    logic [AW-1:0] index;
    logic [31:0]   word_rd;
    logic [31:0]   load_data;
    logic [31:0]   read_q;
    logic          fault_q;

    // Pick the addressed byte/half lanes out of a word and extend to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Merge store data into the old word, touching only the addressed lanes.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign busy  = (state == CLEAR);
    assign req   = bus.MemRead | bus.MemWrite;
    assign index = bus.Address[AW+1:2];

    // Full upper address is compared so aliases above DEPTH words fault.
    assign out_of_range = (bus.Address[31:2] >= 30'(DEPTH));
    assign misalign     = ((bus.Size == 2'b01) && bus.Address[0]) ||
                          (bus.Size[1] && (bus.Address[1:0] != 2'b00));
    assign fault        = req & (misalign | out_of_range) & ~busy;
    assign store_en     = bus.MemWrite & ~busy & ~fault;

    assign word_rd   = mem[index];
    assign load_data = (bus.MemRead & ~busy & ~fault)
                     ? extract(word_rd, bus.Address[1:0], bus.Size, bus.Unsigned)
                     : 32'h0;

    // Clear-sweep FSM and array writes; reset drops any store in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            counter <= '0;
        end else if (state == CLEAR) begin
            mem[counter] <= 32'h0;
            counter      <= counter + 1'b1;
            if (counter == AW'(DEPTH - 1)) state <= IDLE;
        end else if (store_en) begin
            mem[index] <= merge(word_rd, bus.WriteData, bus.Address[1:0], bus.Size);
        end
    end

    // Registered read port; samples pre-store data so same-cycle RMW reads old.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            read_q  <= load_data;
            fault_q <= fault;
        end
    end

    assign bus.Busy     = busy;
    assign bus.ReadData = REG_READ ? read_q  : load_data;
    assign bus.Fault    = REG_READ ? fault_q : fault;
endmodule

// File: doc/data_mem_ext.md
# data_mem_ext

Parametrised data memory for the MIPS datapath: word-organised storage with byte, halfword and word access, sign or zero extension on loads, and alignment and range fault detection. A synchronous reset starts a hardware clear sweep that zeroes the array one word per cycle, with `Busy` high until the sweep ends. The block sits in the MEM stage and can be built with a combinational or a registered read port.

## Interface
- `DEPTH`, 32: number of 32-bit words; must be a power of two, ≥ 2.
- `REG_READ`, 0: 0 = combinational read; 1 = read data registered, one cycle of latency.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `Address`  in  32: byte address; word index is `Address >> 2`.
- `WriteData`  in  32: store data; the byte/half store source is in the low bits.
- `MemRead`  in  1: load request.
- `MemWrite`  in  1: store request.
- `Size`  in  2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `Unsigned`  in  1: 1 = zero-extend a byte/half load; 0 = sign-extend.
- `ReadData`  out  32: extended load data.
- `Busy`  out  1: clear sweep in progress.
- `Fault`  out  1: the current or registered request is misaligned or out of range.

## Operation
- FSM states are CLEAR and IDLE.
  - `reset` = 1 forces CLEAR, sets counter = 0 and holds it at 0.
  - In CLEAR with `reset` = 0: write 0 to `mem[counter]`, then increment `counter`.
  - The write at `counter == DEPTH-1` is the last one; the FSM then goes to IDLE.
  - The counter is $clog2(DEPTH) bits wide.
- `Busy` = 1 in CLEAR. While `Busy` = 1, all requests are ignored: no write, `ReadData` = 0, `Fault` = 0.
- Fault conditions for a request (`MemRead` or `MemWrite` high):
  - half with `Address[0]` = 1;
  - word with `Address[1:0]` ≠ 0;
  - `Address >> 2` ≥ `DEPTH` (the upper address bits are compared, not truncated).
- A faulting request does not write, and its read returns 0.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], with k = `Address[1:0]`.
  - Byte store replaces lane k only.
  - Half store replaces lanes `Address[1]*2` and +1 with `WriteData[15:0]`.
  - Word store replaces all lanes.
- Loads extract the same lanes, then extend to 32 bits per `Unsigned`.
- `ReadData` = 0 when `MemRead` = 0. For `REG_READ` = 1 this applies to the registered copy of `MemRead`.
- When `MemRead` and `MemWrite` are both high, both are performed.

## Timing
- Reset values: `Busy` = 1; `ReadData` = 0; `Fault` = 0; all registered read/fault state = 0.
- Array contents are zero only after the sweep completes.
- Clear latency: `Busy` falls on the edge that writes word DEPTH-1. This is `DEPTH` cycles after the first edge with `reset` = 0.
- Reset asserted mid-sweep restarts the sweep at word 0.
- Reset asserted in IDLE re-enters CLEAR on that edge, and any write presented in that cycle is dropped.
- Stores commit on the rising edge when `MemWrite` & !`Busy` & !fault.
- `REG_READ` = 0:
  - `ReadData` and `Fault` are combinational on the current inputs and array.
  - A store to the address being read shows the old data before the edge and the new data after it.
- `REG_READ` = 1:
  - `ReadData` and `Fault` update on the edge after the request, and hold until the next edge.
  - Read-before-write: a load and a store to the same word in one cycle return the pre-store contents.
- Back-to-back accesses are allowed every cycle; there is no stall except `Busy`.

## Test plan
- Clear sweep (`DEPTH` = 32):
  - Release `reset` and count cycles until `Busy` = 0; it must be exactly 32.
  - Word loads from 0x00 to 0x7C then return 0.
  - Pulse `reset` at sweep cycle 10; `Busy` must stay high for a further 32 cycles.
- Word and partial stores:
  - Store word 0x11223344 at 0x08, then store byte 0xAA at 0x09.
  - A word load at 0x08 then returns 0x1122AA44.
  - Store half 0xBEEF at 0x0A; a word load at 0x08 returns 0xBEEFAA44.
- Extension:
  - Byte load at 0x09: signed returns 0xFFFFFFAA; unsigned returns 0x000000AA.
  - Half load at 0x0A: signed returns 0xFFFFBEEF.
- Faults:
  - Word store at 0x0A, half load at 0x03, and word store at address 0x80 (`DEPTH` = 32) must each raise `Fault`.
  - After these, memory is unchanged and the faulting read returns 0.
- Latency (`REG_READ` = 1):
  - Store 0x5 at 0x10, then in the next cycle issue a load and a store of 0x9 to 0x10 together.
  - The load returns 0x5 one cycle later; a following load returns 0x9.
  - With `MemRead` = 0, `ReadData` must be 0.
- Access during `Busy`:
  - A word store of 0xFFFFFFFF at 0x00 while `Busy` = 1 must be dropped.
  - A load at 0x00 after the sweep returns 0.
